// File: rtl/listing_loader_pkg.sv
// Shared definitions for the listing loader: load modes, FSM states and the
// conventional program base address. The optional read-back verify states are
// only reached when LISTING_LOADER_VERIFY_EN is defined.
package ie_defs;

  typedef enum logic {
    LD_SPARSE = 1'b0,
    LD_CONTIG = 1'b1
  } loader_mode_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_A,
    ST_LAT_A,
    ST_RD_D,
    ST_LAT_D,
    ST_WRITE,
    ST_VRD,
    ST_VCMP,
    ST_FIN
  } loader_state_t;

  localparam logic [15:0] PROG_BASE = 16'h0200;

endpackage

// File: rtl/listing_loader_if.sv
// Listing ROM read port and CPU memory write port seen by the loader.
// LISTING_LOADER_VERIFY_EN adds the memory read-back pair mem_re/mem_rdata.
interface listing_loader_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SRC_AW = 8,
  parameter int unsigned CH_W   = 1
);
  logic [CH_W-1:0]   src_ch;
  logic [SRC_AW-1:0] src_idx;
  logic              src_rd;
  logic [ADDR_W-1:0] src_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_ready;
`ifdef LISTING_LOADER_VERIFY_EN
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output src_ch, src_idx, src_rd, mem_addr, mem_wdata, mem_we, mem_re,
    input  src_data, mem_ready, mem_rdata
  );
  modport slave (
    input  src_ch, src_idx, src_rd, mem_addr, mem_wdata, mem_we, mem_re,
    output src_data, mem_ready, mem_rdata
  );
`else
  modport master (
    output src_ch, src_idx, src_rd, mem_addr, mem_wdata, mem_we,
    input  src_data, mem_ready
  );
  modport slave (
    input  src_ch, src_idx, src_rd, mem_addr, mem_wdata, mem_we,
    output src_data, mem_ready
  );
`endif
endinterface

// File: rtl/listing_loader.sv
// Boot-time listing loader: copies a sparse {addr,data} or contiguous listing
// from the listing ROM into CPU memory while holding the CPU, then releases it.
// Define LISTING_LOADER_VERIFY_EN to read back and compare every written byte.
module listing_loader
  import ie_defs::*;
#(
  parameter  int unsigned ADDR_W = 16,
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned SRC_AW = 8,
  parameter  int unsigned NUM_CH = 2,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic              mode,
  input  logic [SRC_AW:0]   len,
  input  logic [ADDR_W-1:0] base_addr,
  listing_loader_if.master  bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
`ifdef LISTING_LOADER_VERIFY_EN
  output logic [ADDR_W-1:0] err_addr,
`endif
  output logic              err
);

  localparam logic [SRC_AW:0] LIM_CONTIG = {1'b1, {SRC_AW{1'b0}}};
  localparam logic [SRC_AW:0] LIM_SPARSE = LIM_CONTIG >> 1;
  localparam logic [SRC_AW:0] CNT_ONE    = {{SRC_AW{1'b0}}, 1'b1};

  loader_state_t     r_state, w_next, w_entry_st;
  loader_mode_t      r_mode;
  logic [CH_W-1:0]   r_ch;
  logic [SRC_AW:0]   r_len, r_cnt;
  logic [ADDR_W-1:0] r_base, r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_cpu_hold, r_done, r_err;
  logic              w_start_ok, w_len_bad, w_accept, w_entry_done, w_last;
`ifdef LISTING_LOADER_VERIFY_EN
  logic [ADDR_W-1:0] r_err_addr;
`endif

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_len_bad  = (loader_mode_t'(mode) == LD_CONTIG) ? (len > LIM_CONTIG)
                                                          : (len > LIM_SPARSE);
  assign w_accept   = (r_state == ST_WRITE) && bus.mem_ready;
  assign w_last     = (r_cnt + CNT_ONE) == r_len;
  assign w_entry_st = (r_mode == LD_CONTIG) ? ST_RD_D : ST_RD_A;
`ifdef LISTING_LOADER_VERIFY_EN
  assign w_entry_done = (r_state == ST_VCMP);
`else
  assign w_entry_done = w_accept;
`endif

  // State register; reset aborts any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state: one pass per entry, FIN always lasts exactly one cycle.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (len == '0 || w_len_bad)                  w_next = ST_FIN;
          else if (loader_mode_t'(mode) == LD_CONTIG)  w_next = ST_RD_D;
          else                                         w_next = ST_RD_A;
        end
      end
      ST_RD_A:  w_next = ST_LAT_A;
      ST_LAT_A: w_next = ST_RD_D;
      ST_RD_D:  w_next = ST_LAT_D;
      ST_LAT_D: w_next = ST_WRITE;
      ST_WRITE: begin
        if (bus.mem_ready) begin
`ifdef LISTING_LOADER_VERIFY_EN
          w_next = ST_VRD;
`else
          w_next = w_last ? ST_FIN : w_entry_st;
`endif
        end
      end
      ST_VRD:   w_next = ST_VCMP;
      ST_VCMP:  w_next = w_last ? ST_FIN : w_entry_st;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; addr/data come straight from holding registers
  // so they cannot move while a write is stalled.
  always_comb begin
    busy          = (r_state != ST_IDLE) && (r_state != ST_FIN);
    bus.src_rd    = (r_state == ST_RD_A) || (r_state == ST_RD_D);
    bus.src_idx   = '0;
    if (bus.src_rd) begin
      bus.src_idx = (r_mode == LD_CONTIG) ? r_cnt[SRC_AW-1:0]
                                          : {r_cnt[SRC_AW-2:0], r_state == ST_RD_D};
    end
    bus.src_ch    = r_ch;
    bus.mem_addr  = r_addr;
    bus.mem_wdata = r_data;
    bus.mem_we    = (r_state == ST_WRITE);
`ifdef LISTING_LOADER_VERIFY_EN
    bus.mem_re    = (r_state == ST_VRD);
    err_addr      = r_err_addr;
`endif
    cpu_hold      = r_cpu_hold;
    done          = r_done;
    err           = r_err;
  end

  // Load parameters, entry counter, captured ROM words and sticky flags.
  // err is cleared together with done by an accepted start so each load
  // reports only its own errors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode     <= LD_SPARSE;
      r_ch       <= '0;
      r_len      <= '0;
      r_base     <= ADDR_W'(PROG_BASE);
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef LISTING_LOADER_VERIFY_EN
      r_err_addr <= '0;
`endif
    end else begin
      if (w_start_ok) begin
        r_mode     <= loader_mode_t'(mode);
        r_ch       <= ch_sel;
        r_len      <= len;
        r_base     <= base_addr;
        r_cnt      <= '0;
        r_cpu_hold <= 1'b1;
        r_done     <= 1'b0;
        r_err      <= w_len_bad;
      end
      if (r_state == ST_LAT_A) r_addr <= bus.src_data;
      if (r_state == ST_LAT_D) begin
        r_data <= bus.src_data[DATA_W-1:0];
        if (r_mode == LD_CONTIG) r_addr <= r_base + ADDR_W'(r_cnt);
      end
      if (w_entry_done) r_cnt <= r_cnt + CNT_ONE;
`ifdef LISTING_LOADER_VERIFY_EN
      if (r_state == ST_VCMP && bus.mem_rdata != r_data) begin
        r_err      <= 1'b1;
        r_err_addr <= r_addr;
      end
`endif
      if (w_next == ST_FIN && r_state != ST_FIN) begin
        r_done     <= 1'b1;
        r_cpu_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_listing_loader.sv
// Scoreboard bench for listing_loader: stimulus pushes expected memory writes,
// a monitor pops and compares each accepted write. Also covers the
// LISTING_LOADER_VERIFY_EN build when that macro is defined.
`timescale 1ns/1ps
module tb_listing_loader;
  import ie_defs::*;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SRC_AW = 8;
  localparam int unsigned NUM_CH = 2;
`ifdef LISTING_LOADER_VERIFY_EN
  localparam int VX = 2;
`else
  localparam int VX = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [0:0]        ch_sel = '0;
  logic              mode = 1'b0;
  logic [SRC_AW:0]   len = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              cpu_hold, busy, done, err;
`ifdef LISTING_LOADER_VERIFY_EN
  logic [ADDR_W-1:0] err_addr;
  logic              corrupt = 1'b0;
`endif

  listing_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_AW(SRC_AW), .CH_W(1)) bus ();

  listing_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_AW(SRC_AW), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .start(start), .ch_sel(ch_sel), .mode(mode), .len(len),
    .base_addr(base_addr), .bus(bus), .cpu_hold(cpu_hold), .busy(busy), .done(done),
`ifdef LISTING_LOADER_VERIFY_EN
    .err_addr(err_addr),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   wr_count = 0;
  logic [15:0] rom [NUM_CH][256];
  logic [7:0]  mem [65536];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Listing ROM: one-cycle read latency.
  always @(posedge clk) if (bus.src_rd) bus.src_data <= rom[bus.src_ch][bus.src_idx];

  // CPU memory model.
  always @(posedge clk) if (bus.mem_we && bus.mem_ready) mem[bus.mem_addr] <= bus.mem_wdata;
`ifdef LISTING_LOADER_VERIFY_EN
  always @(posedge clk)
    if (bus.mem_re)
      bus.mem_rdata <= (corrupt && bus.mem_addr == 16'h0201) ? 8'h00 : mem[bus.mem_addr];
`endif

  // mem_ready: optionally held low for a few cycles on a chosen write.
  logic stall_en = 1'b0;
  int   stall_at = 0;
  int   stall_left = 0;
  initial bus.mem_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (stall_en && bus.mem_we && wr_count == stall_at && stall_left > 0) begin
      bus.mem_ready = 1'b0;
      stall_left--;
    end else begin
      bus.mem_ready = 1'b1;
    end
  end

  // Monitor: compare accepted writes against the scoreboard; check that a
  // stalled write keeps its address and data.
  logic        stall_prev = 1'b0;
  logic [15:0] st_a;
  logic [7:0]  st_d;
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      if (stall_prev) begin
        chk("stall_we", bus.mem_we, 1);
        chk("stall_addr", bus.mem_addr, st_a);
        chk("stall_data", bus.mem_wdata, st_d);
      end
      if (bus.mem_we && bus.mem_ready) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          chk("write_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.mem_addr, e.a);
          chk("wr_data", bus.mem_wdata, e.d);
        end
      end
      stall_prev = bus.mem_we && !bus.mem_ready;
      st_a = bus.mem_addr;
      st_d = bus.mem_wdata;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  task automatic run_load(input int ch, input logic md, input int ln, input logic [15:0] base,
                          input int exp_cyc, input logic exp_err, input int exp_wr,
                          input string tag, input bit fin_poke);
    int n = 0;
    int w0;
    w0 = wr_count;
    ch_sel = 1'(ch); mode = md; len = 9'(ln); base_addr = base; start = 1'b1;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (n == 1 && exp_cyc > 1) begin
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_hold_run"}, cpu_hold, 1);
      end
    end while (!done && n < 300);
    chk({tag, "_cycles"}, n, exp_cyc);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_hold_rel"}, cpu_hold, 0);
    chk({tag, "_busy_fin"}, busy, 0);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_writes"}, wr_count - w0, exp_wr);
    chk({tag, "_queue"}, exp_q.size(), 0);
    if (fin_poke) begin
      // start presented while in FIN must be ignored
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_finstart_busy"}, busy, 0);
      chk({tag, "_finstart_done"}, done, 1);
      chk({tag, "_finstart_hold"}, cpu_hold, 0);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_src_rd"}, bus.src_rd, 0);
    chk({tag, "_src_idx"}, bus.src_idx, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  initial begin
    int w0;
    int k;
    logic reached;
    for (int c = 0; c < int'(NUM_CH); c++)
      for (int i = 0; i < 256; i++) rom[c][i] = 16'h0000;
    rom[0][0] = 16'h00A2; rom[0][1] = 16'h0000; rom[0][2] = 16'h008A;
    rom[1][0] = 16'h001E; rom[1][1] = 16'h00AA; rom[1][2] = 16'h001F; rom[1][3] = 16'h00BB;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // contiguous channel 0 at the program base
    push(16'h0200, 8'hA2); push(16'h0201, 8'h00); push(16'h0202, 8'h8A);
    run_load(0, LD_CONTIG, 3, PROG_BASE, 3*(3+VX)+1, 1'b0, 3, "contig", 1'b1);
    chk("contig_mem_0202", mem[16'h0202], 8'h8A);

    // sparse channel 1
    push(16'h001E, 8'hAA); push(16'h001F, 8'hBB);
    run_load(1, LD_SPARSE, 2, 16'h0000, 2*(5+VX)+1, 1'b0, 2, "sparse", 1'b0);

    // second write stalled for four cycles
    push(16'h0200, 8'hA2); push(16'h0201, 8'h00); push(16'h0202, 8'h8A);
    stall_en = 1'b1; stall_at = wr_count + 1; stall_left = 4;
    run_load(0, LD_CONTIG, 3, PROG_BASE, 3*(3+VX)+1+4, 1'b0, 3, "stall", 1'b0);
    stall_en = 1'b0;

    // contiguous address wraps past the top of memory without error
    push(16'hFFFF, 8'hA2); push(16'h0000, 8'h00);
    run_load(0, LD_CONTIG, 2, 16'hFFFF, 2*(3+VX)+1, 1'b0, 2, "wrap", 1'b0);

    // empty listing and over-long listings
    run_load(0, LD_CONTIG, 0, PROG_BASE, 1, 1'b0, 0, "len0", 1'b0);
    run_load(0, LD_CONTIG, 300, PROG_BASE, 1, 1'b1, 0, "len300", 1'b0);
    run_load(0, LD_CONTIG, 257, PROG_BASE, 1, 1'b1, 0, "len257", 1'b0);
    run_load(1, LD_SPARSE, 129, PROG_BASE, 1, 1'b1, 0, "sp129", 1'b0);

    // reset while the second write is pending
    mem[16'h0200] = 8'h55;
    push(16'h0200, 8'hA2); push(16'h0201, 8'h00); push(16'h0202, 8'h8A);
    w0 = wr_count;
    ch_sel = 1'b0; mode = LD_CONTIG; len = 9'd3; base_addr = PROG_BASE; start = 1'b1;
    reached = 1'b0;
    k = 0;
    while (!reached && k < 50) begin
      @(posedge clk); #1;
      start = 1'b0;
      k++;
      if (wr_count == w0 + 1 && bus.mem_we) reached = 1'b1;
    end
    chk("midload_reached", reached, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    chk("abort_partial_mem", mem[16'h0200], 8'hA2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    push(16'h0200, 8'hA2); push(16'h0201, 8'h00); push(16'h0202, 8'h8A);
    run_load(0, LD_CONTIG, 3, PROG_BASE, 3*(3+VX)+1, 1'b0, 3, "restart", 1'b0);

`ifdef LISTING_LOADER_VERIFY_EN
    // read-back of 0201 returns 00 while 01 was written
    rom[0][1] = 16'h0001;
    corrupt = 1'b1;
    push(16'h0200, 8'hA2); push(16'h0201, 8'h01); push(16'h0202, 8'h8A);
    run_load(0, LD_CONTIG, 3, PROG_BASE, 3*(3+VX)+1, 1'b1, 3, "verify", 1'b0);
    chk("verify_err_addr", err_addr, 16'h0201);
    corrupt = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
